// File: rtl/dsm_pkg.sv
// rtl/dsm_pkg.sv - shared constants, OSR lookup and saturating add for the dsm2/sinc3 pair
package dsm_pkg;

  localparam int DW    = 16;
  localparam int I1W   = 20;
  localparam int I2W   = 24;
  localparam int SW    = I2W + 1;
  localparam int CLAMP = 24576;
  localparam int FS    = 1 << (DW - 1);
  localparam int OCW   = 9;

  typedef enum logic [1:0] {
    MODE_OSR32  = 2'd0,
    MODE_OSR64  = 2'd1,
    MODE_OSR128 = 2'd2,
    MODE_OSR256 = 2'd3
  } mode_e;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  function automatic logic [OCW-1:0] osr_of(input logic [1:0] mode);
    logic [OCW-1:0] osr;
    case (mode_e'(mode))
      MODE_OSR32:  osr = 9'd32;
      MODE_OSR64:  osr = 9'd64;
      MODE_OSR128: osr = 9'd128;
      MODE_OSR256: osr = 9'd256;
      default:     osr = 9'd32;
    endcase
    return osr;
  endfunction

  // Three-term sum in SW bits (cannot overflow there), clipped to a w-bit signed range.
  function automatic logic signed [SW-1:0] sat_add(
    input logic signed [SW-1:0] a,
    input logic signed [SW-1:0] b,
    input logic signed [SW-1:0] c,
    input int                   w
  );
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] hi;
    logic signed [SW-1:0] lo;
    hi  = SW'((1 <<< (w - 1)) - 1);
    lo  = ~hi;
    sum = a + b + c;
    if (sum > hi) begin
      return hi;
    end else if (sum < lo) begin
      return lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/dsm2_core.sv
// rtl/dsm2_core.sv - second-order integrator pair and 1-bit quantizer producing MDAT
module dsm2_core
  import dsm_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic signed [DW-1:0] x_i,
  output logic                 mdat_o
);

  logic signed [I1W-1:0] int1_q, int1_d;
  logic signed [I2W-1:0] int2_q, int2_d;
  logic                  mdat_q, mdat_d;
  logic signed [SW-1:0]  fb;
  logic signed [SW-1:0]  s1;
  logic signed [SW-1:0]  s2;

  // Both integrators consume the old int1 and the registered MDAT as feedback.
  always_comb begin
    fb     = mdat_q ? SW'(FS) : -SW'(FS);
    s1     = sat_add(SW'(int1_q), SW'(x_i), -fb, I1W);
    s2     = sat_add(SW'(int2_q), SW'(int1_q), -fb, I2W);
    int1_d = s1[I1W-1:0];
    int2_d = s2[I2W-1:0];
    mdat_d = ~int2_d[I2W-1];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      int1_q <= '0;
      int2_q <= '0;
      mdat_q <= 1'b0;
    end else begin
      int1_q <= int1_d;
      int2_q <= int2_d;
      mdat_q <= mdat_d;
    end
  end

  assign mdat_o = mdat_q;

endmodule

// File: rtl/dsm2_bitstream_gen.sv
// rtl/dsm2_bitstream_gen.sv - PCM input buffer, clamp, OSR framing and flags around dsm2_core
module dsm2_bitstream_gen
  import dsm_pkg::*;
(
  input  logic                 MCLK,
  input  logic                 RST,
  input  logic [1:0]           MODE,
  input  logic signed [DW-1:0] DIN,
  input  logic                 DIN_VLD,
  output logic                 DIN_RDY,
  output logic                 MDAT,
  output logic                 SMPL_STRB,
  output logic                 UNDERRUN
);

  localparam logic signed [DW-1:0] CLAMP_HI = DW'(CLAMP);
  localparam logic signed [DW-1:0] CLAMP_LO = DW'(-CLAMP);

  buf_state_e            buf_q, buf_d;
  logic signed [DW-1:0]  buf_data_q, buf_data_d;
  logic signed [DW-1:0]  x_q, x_d;
  logic signed [DW-1:0]  din_clamped;
  logic [1:0]            mode_q, mode_d;
  logic [OCW-2:0]        osr_cnt_q, osr_cnt_d;
  logic                  strb_q, strb_d;
  logic                  underrun_q, underrun_d;
  logic                  boundary;
  logic                  accept;

  always_comb begin
    din_clamped = DIN;
    if (DIN > CLAMP_HI) begin
      din_clamped = CLAMP_HI;
    end else if (DIN < CLAMP_LO) begin
      din_clamped = CLAMP_LO;
    end
  end

  assign boundary = ({1'b0, osr_cnt_q} == (osr_of(mode_q) - 9'd1));
  assign accept   = DIN_VLD && (buf_q == BUF_EMPTY);

  // The boundary looks at the buffer as it stood at the start of the cycle, so a word
  // accepted on the boundary itself waits a full period before reaching x.
  always_comb begin
    buf_d      = buf_q;
    buf_data_d = buf_data_q;
    x_d        = x_q;
    mode_d     = mode_q;
    osr_cnt_d  = osr_cnt_q + 8'd1;
    strb_d     = 1'b0;
    underrun_d = underrun_q;
    if (boundary) begin
      osr_cnt_d = '0;
      strb_d    = 1'b1;
      mode_d    = MODE;
      if (buf_q == BUF_FULL) begin
        x_d   = buf_data_q;
        buf_d = BUF_EMPTY;
      end else begin
        underrun_d = 1'b1;
      end
    end
    if (accept) begin
      buf_d      = BUF_FULL;
      buf_data_d = din_clamped;
    end
  end

  always_ff @(posedge MCLK) begin
    if (!RST) begin
      buf_q      <= BUF_EMPTY;
      buf_data_q <= '0;
      x_q        <= '0;
      mode_q     <= MODE;
      osr_cnt_q  <= '0;
      strb_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      buf_data_q <= buf_data_d;
      x_q        <= x_d;
      mode_q     <= mode_d;
      osr_cnt_q  <= osr_cnt_d;
      strb_q     <= strb_d;
      underrun_q <= underrun_d;
    end
  end

  assign DIN_RDY   = (buf_q == BUF_EMPTY);
  assign SMPL_STRB = strb_q;
  assign UNDERRUN  = underrun_q;

  dsm2_core u_core (
    .clk_i  (MCLK),
    .rst_ni (RST),
    .x_i    (x_q),
    .mdat_o (MDAT)
  );

endmodule

// File: tb/tb_dsm2_bitstream_gen.sv
// tb/tb_dsm2_bitstream_gen.sv - scoreboard bench: per-strobe expectations popped by a monitor
module tb_dsm2_bitstream_gen;

  localparam int IGN = -1000000;

  typedef struct {
    string name;
    int    gap;
    int    undr;
    int    x;
    int    rdy;
    int    omode;
    int    oexp;
    int    otol;
  } exp_t;

  logic               MCLK;
  logic               RST;
  logic [1:0]         MODE;
  logic signed [15:0] DIN;
  logic               DIN_VLD;
  logic               DIN_RDY;
  logic               MDAT;
  logic               SMPL_STRB;
  logic               UNDERRUN;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;
  logic sat_hit = 1'b0;

  dsm2_bitstream_gen dut (
    .MCLK      (MCLK),
    .RST       (RST),
    .MODE      (MODE),
    .DIN       (DIN),
    .DIN_VLD   (DIN_VLD),
    .DIN_RDY   (DIN_RDY),
    .MDAT      (MDAT),
    .SMPL_STRB (SMPL_STRB),
    .UNDERRUN  (UNDERRUN)
  );

  initial begin
    MCLK = 1'b0;
    forever #5 MCLK = ~MCLK;
  end

  function automatic void check(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act > exp + tol || act < exp - tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (+/- %0d)", name, act, exp, tol);
    end
  endfunction

  function automatic void push(input string n, input int gap, input int undr, input int x,
                               input int rdy, input int om, input int oe, input int ot);
    exp_t e;
    e.name = n; e.gap = gap; e.undr = undr; e.x = x; e.rdy = rdy;
    e.omode = om; e.oexp = oe; e.otol = ot;
    sb_q.push_back(e);
  endfunction

  // Monitor: counts cycles and ones; on every strobe pops and checks one expectation.
  initial begin
    int   cyc;
    int   last;
    int   acc;
    int   i1;
    int   i2;
    exp_t e;
    cyc = 0; last = 0; acc = 0;
    forever begin
      @(negedge MCLK);
      if (!mon_en) begin
        cyc = 0; last = 0; acc = 0;
      end else begin
        cyc++;
        acc += int'(MDAT);
        i1 = int'(dut.u_core.int1_q);
        i2 = int'(dut.u_core.int2_q);
        if (i1 >= 524287 || i1 <= -524288 || i2 >= 8388607 || i2 <= -8388608) sat_hit = 1'b1;
        if (SMPL_STRB && sb_q.size() > 0) begin
          e = sb_q.pop_front();
          if (e.gap != IGN) check({e.name, "_gap"}, cyc - last, e.gap, 0);
          if (e.undr != IGN) check({e.name, "_underrun"}, int'(UNDERRUN), e.undr, 0);
          if (e.x != IGN) check({e.name, "_x"}, int'(dut.x_q), e.x, 0);
          if (e.rdy != IGN) check({e.name, "_rdy"}, int'(DIN_RDY), e.rdy, 0);
          if (e.omode == 1) begin
            acc = 0;
          end else if (e.omode == 2) begin
            check({e.name, "_ones"}, acc, e.oexp, e.otol);
            acc = 0;
          end
          last = cyc;
        end
      end
    end
  end

  task automatic start(input logic [1:0] m, input logic v, input int d);
    @(posedge MCLK);
    #1;
    mon_en  = 1'b0;
    RST     = 1'b0;
    MODE    = m;
    DIN_VLD = v;
    DIN     = 16'(d);
    sat_hit = 1'b0;
    sb_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(posedge MCLK);
      #1;
      check("rst_mdat", int'(MDAT), 0, 0);
      check("rst_rdy", int'(DIN_RDY), 1, 0);
      check("rst_underrun", int'(UNDERRUN), 0, 0);
      check("rst_strb", int'(SMPL_STRB), 0, 0);
    end
    RST = 1'b1;
    @(posedge MCLK);
    #1;
    mon_en = 1'b1;
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < max_cyc) begin
      @(posedge MCLK);
      n++;
    end
    check("drain_pending", sb_q.size(), 0, 0);
  endtask

  task automatic density(input string n, input int din, input int xexp, input int ones);
    start(2'd1, 1'b1, din);
    for (int i = 1; i <= 132; i++) begin
      if (i == 1) push({n, "_s1"}, 64, 0, xexp, 1, 0, 0, 0);
      else if (i == 4) push({n, "_s4"}, 64, 0, xexp, IGN, 1, 0, 0);
      else if (i == 132) push({n, "_win"}, 64, 0, xexp, IGN, 2, ones, 16);
      else push({n, "_sN"}, 64, IGN, IGN, IGN, 0, 0, 0);
    end
    drain(9000);
    check({n, "_no_sat"}, int'(sat_hit), 0, 0);
  endtask

  initial begin
    logic [3:0] first_bits;
    int         stall;
    RST = 1'b0; MODE = 2'd0; DIN = '0; DIN_VLD = 1'b0;

    // Idle start: first boundary finds the buffer empty.
    start(2'd0, 1'b0, 0);
    push("t1_s1", 32, 1, 0, 1, 0, 0, 0);
    push("t1_s2", 32, 1, 0, 1, 0, 0, 0);
    repeat (10) @(negedge MCLK);
    check("t1_underrun_pre", int'(UNDERRUN), 0, 0);
    drain(200);

    // Zero input at OSR 256.
    start(2'd3, 1'b1, 0);
    for (int i = 1; i <= 32; i++) begin
      if (i == 1) push("t2_s1", 256, 0, 0, 1, 0, 0, 0);
      else if (i == 32) push("t2_win", 256, 0, 0, IGN, 2, 4096, 4);
      else push("t2_sN", 256, IGN, IGN, IGN, 0, 0, 0);
    end
    first_bits = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      @(negedge MCLK);
      check("t2_first_bits", int'(MDAT), int'(first_bits[3-i]), 0);
    end
    drain(9000);
    check("t2_no_sat", int'(sat_hit), 0, 0);

    density("t3_pos", 16384, 16384, 6144);
    density("t3_neg", -16384, -16384, 2048);
    density("t4_pos", 32767, 24576, 7168);
    density("t4_neg", -32768, -24576, 1024);

    // Back-to-back words: the second stalls until the boundary frees the buffer.
    start(2'd0, 1'b0, 0);
    push("t5a_s1", 32, 0, 1000, 1, 0, 0, 0);
    push("t5a_s2", 32, 0, -24576, 1, 0, 0, 0);
    push("t5a_s3", 32, 1, -24576, 1, 0, 0, 0);
    repeat (3) @(posedge MCLK);
    #1; DIN = 16'sd1000; DIN_VLD = 1'b1;
    @(posedge MCLK);
    #1; DIN = -16'sd30000;
    stall = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge MCLK);
      if (DIN_RDY) break;
      stall++;
    end
    check("t5a_stall_cycles", stall, 27, 0);
    check("t5a_rdy_on_strobe", int'(SMPL_STRB), 1, 0);
    @(posedge MCLK);
    #1; DIN_VLD = 1'b0;
    drain(200);

    // A buffered word is dropped by reset.
    @(posedge MCLK);
    #1; DIN = 16'sd5000; DIN_VLD = 1'b1;
    @(posedge MCLK);
    #1; DIN_VLD = 1'b0;
    @(negedge MCLK);
    check("t5r_buffer_full", int'(DIN_RDY), 0, 0);
    start(2'd0, 1'b0, 0);
    push("t5r_s1", 32, 1, 0, 1, 0, 0, 0);
    drain(200);

    // Word offered on the boundary cycle reaches x one period later.
    start(2'd0, 1'b0, 0);
    push("t5b_s1", 32, 1, 0, 0, 0, 0, 0);
    push("t5b_s2", 32, 1, 12345, 1, 0, 0, 0);
    repeat (30) @(posedge MCLK);
    #1; DIN = 16'sd12345; DIN_VLD = 1'b1;
    @(posedge MCLK);
    #1; DIN_VLD = 1'b0;
    drain(200);

    // MODE 3->0 mid-period waits for the 256-cycle period to finish.
    start(2'd3, 1'b0, 0);
    push("t5c_s1", 256, 1, 0, 1, 0, 0, 0);
    push("t5c_s2", 32, 1, 0, 1, 0, 0, 0);
    push("t5c_s3", 32, 1, 0, 1, 0, 0, 0);
    repeat (100) @(posedge MCLK);
    #1; MODE = 2'd0;
    drain(1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion before it");
    $fatal(1, "watchdog");
  end

endmodule
